// File: rtl/nes_pkg.sv
// Shared constants and state encoding for the NES pad link blocks.
package nes_pkg;

  localparam int unsigned NES_NUM_BUTTONS = 8;
  localparam int unsigned BIT_IDX_W       = 4;

  // Button bit positions, also the host read order (A is shifted out first).
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Level shifted into the register behind the last button, as on a real pad.
  localparam logic NES_FILL_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_t;

endpackage

// File: rtl/nes_btn_debounce.sv
// Single-bit debouncer: output follows input only after CYCLES consecutive
// samples that differ from the current output. Resets to released (0).
module nes_btn_debounce #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(CYCLES - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nes_pad_responder.sv
// NES pad emulation (4021-style shifter) driven by host latch/pulse pins.
// Optional per-button debouncing when NES_PAD_DEBOUNCE_EN is defined.
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NES_NUM_BUTTONS-1:0] buttons,
  input  logic                       nes_latch,
  input  logic                       nes_pulse,
  output logic                       nes_data,
  output logic                       frame_done,
  output logic [BIT_IDX_W-1:0]       bit_idx
);

  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_deb_chk
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Host pin synchronisers and edge history.
  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] pulse_sync;
  logic                   latch_prev;
  logic                   pulse_prev;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   pulse_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_prev <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], nes_pulse};
      latch_prev <= latch_sync[SYNC_STAGES-1];
      pulse_prev <= pulse_sync[SYNC_STAGES-1];
    end
  end

  assign latch_rise =  latch_sync[SYNC_STAGES-1] & ~latch_prev;
  assign latch_fall = ~latch_sync[SYNC_STAGES-1] &  latch_prev;
  assign pulse_rise =  pulse_sync[SYNC_STAGES-1] & ~pulse_prev;

  // Button inputs are board-level and asynchronous.
  logic [NES_NUM_BUTTONS-1:0] btn_meta;
  logic [NES_NUM_BUTTONS-1:0] btn_sync;
  logic [NES_NUM_BUTTONS-1:0] btn_clean;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= buttons;
      btn_sync <= btn_meta;
    end
  end

`ifdef NES_PAD_DEBOUNCE_EN
  for (genvar gi = 0; gi < NES_NUM_BUTTONS; gi++) begin : g_deb
    nes_btn_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .din   (btn_sync[gi]),
      .dout  (btn_clean[gi])
    );
  end
`else
  assign btn_clean = btn_sync;
`endif

  // Frame FSM and shifter.
  nes_state_t                 state;
  nes_state_t                 state_nx;
  logic [NES_NUM_BUTTONS-1:0] shift_reg;
  logic [NES_NUM_BUTTONS-1:0] shift_nx;
  logic [BIT_IDX_W-1:0]       idx_nx;
  logic                       done_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '1;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      shift_reg  <= shift_nx;
      bit_idx    <= idx_nx;
      frame_done <= done_nx;
    end
  end

  // Latch rise pre-empts everything, including a coincident pulse edge.
  always_comb begin
    state_nx = state;
    shift_nx = shift_reg;
    idx_nx   = bit_idx;
    done_nx  = 1'b0;
    if (latch_rise) begin
      state_nx = ST_LOAD;
      shift_nx = ~btn_clean;
      idx_nx   = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          shift_nx = ~btn_clean;
          idx_nx   = '0;
          if (latch_fall) state_nx = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (pulse_rise) begin
            shift_nx = {NES_FILL_LEVEL, shift_reg[NES_NUM_BUTTONS-1:1]};
            idx_nx   = bit_idx + BIT_IDX_W'(1);
            if (bit_idx == BIT_IDX_W'(NES_NUM_BUTTONS - 1)) begin
              done_nx  = 1'b1;
              state_nx = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign nes_data = shift_reg[0];

endmodule
